// File: rtl/arb_tcp_serializer_if.sv
// Signal bundle between the arbiter/TCP side and arb_tcp_serializer.
// The master side is the environment; the slave side is the serializer.
interface arb_tcp_serializer_if #(
    parameter int DEPTH = 512
);
    localparam int SW = $clog2(DEPTH) + 1;

    logic          WRITE_IN;
    logic [31:0]   DATA_IN;
    logic          READY_OUT;
    logic [7:0]    TX_DATA;
    logic          TX_WR;
    logic          TX_FULL;
    logic          FIFO_FULL;
    logic          FIFO_NEAR_FULL;
    logic [SW-1:0] FIFO_SIZE;
    logic [7:0]    OVERFLOW_CNT;
    logic [31:0]   WORD_CNT;

    modport master (
        output WRITE_IN, DATA_IN, TX_FULL,
        input  READY_OUT, TX_DATA, TX_WR, FIFO_FULL, FIFO_NEAR_FULL,
               FIFO_SIZE, OVERFLOW_CNT, WORD_CNT
    );

    modport slave (
        input  WRITE_IN, DATA_IN, TX_FULL,
        output READY_OUT, TX_DATA, TX_WR, FIFO_FULL, FIFO_NEAR_FULL,
               FIFO_SIZE, OVERFLOW_CNT, WORD_CNT
    );
endinterface

// File: rtl/arb_tcp_serializer.sv
// Buffers 32-bit arbiter words and streams them MSB-byte-first to a TCP byte FIFO.
// Define ARB_TCP_SERIALIZER_WORD_CNT_EN to build the transmitted-word counter.
//
// state  | meaning
// S_IDLE | holding register empty, waiting for a FIFO word
// S_SEND | holding register valid, emitting byte idx (3..0)
module arb_tcp_serializer #(
    parameter int DEPTH            = 512,
    parameter int NEAR_FULL_MARGIN = 8
) (
    input  logic                BUS_CLK,
    input  logic                BUS_RST,
    arb_tcp_serializer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;
    localparam logic [SW-1:0] DEPTH_C  = SW'(DEPTH);
    localparam logic [SW-1:0] NF_LEVEL = SW'(DEPTH - NEAR_FULL_MARGIN);

    if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 16");
    end

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [SW-1:0] count_q, count_d;
    logic [31:0]   hold_q, hold_d;
    logic [1:0]    idx_q, idx_d;
    logic          ready_q;
    logic [7:0]    ovf_q;
    logic          full, empty, push, drop, pop, tx_wr, hold_valid;

    // Fullness is judged on the registered count, so a pop in the same cycle cannot rescue a write.
    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == '0);
    assign push       = bus.WRITE_IN & ~full & ~BUS_RST;
    assign drop       = bus.WRITE_IN & full;
    assign hold_valid = (state_q == S_SEND);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        tx_wr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    hold_d  = mem_q[rd_ptr_q];
                    idx_d   = 2'd3;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                tx_wr = ~bus.TX_FULL & ~BUS_RST;
                if (tx_wr) begin
                    if (idx_q != 2'd0) begin
                        idx_d = idx_q - 2'd1;
                    end else if (!empty) begin
                        pop    = 1'b1;
                        hold_d = mem_q[rd_ptr_q];
                        idx_d  = 2'd3;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q  <= S_IDLE;
            hold_q   <= '0;
            idx_q    <= 2'd3;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            ovf_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            ready_q <= (count_q < NF_LEVEL);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (push) mem_q[wr_ptr_q] <= bus.DATA_IN;
    end

`ifdef ARB_TCP_SERIALIZER_WORD_CNT_EN
    logic [31:0] word_cnt_q;
    logic        word_done;

    assign word_done = tx_wr && (idx_q == 2'd0);

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            word_cnt_q <= '0;
        end else if (word_done) begin
            word_cnt_q <= word_cnt_q + 32'd1;
        end
    end

    assign bus.WORD_CNT = word_cnt_q;
`else
    assign bus.WORD_CNT = '0;
`endif

    assign bus.READY_OUT      = ready_q & ~BUS_RST;
    assign bus.TX_WR          = tx_wr;
    assign bus.TX_DATA        = (hold_valid && !BUS_RST) ? hold_q[{idx_q, 3'b000} +: 8] : 8'h00;
    assign bus.FIFO_FULL      = full;
    assign bus.FIFO_NEAR_FULL = (count_q >= NF_LEVEL);
    assign bus.FIFO_SIZE      = count_q;
    assign bus.OVERFLOW_CNT   = ovf_q;
endmodule

// File: tb/tb_arb_tcp_serializer.sv
// Self-checking bench for arb_tcp_serializer against a queue-based reference model.
module tb_arb_tcp_serializer;
    localparam int DEPTH = 32;
    localparam int M     = 8;
    localparam int SW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arb_tcp_serializer_if #(.DEPTH(DEPTH)) bus ();

    arb_tcp_serializer #(.DEPTH(DEPTH), .NEAR_FULL_MARGIN(M)) dut (
        .BUS_CLK(clk),
        .BUS_RST(rst),
        .bus    (bus)
    );

    // Reference model: word queue for the local FIFO, byte queue for the word in flight.
    logic [31:0] mq[$];
    logic [7:0]  hb[$];
    int          ovf_m  = 0;
    int          wcnt_m = 0;
    bit          ready_m = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    logic [SW+43:0] a_vec, e_vec;
    logic [7:0]     a_byte, e_byte;
    logic           a_txwr, a_ready;
    bit             e_valid;

    function automatic logic [31:0] exp_wc();
`ifdef ARB_TCP_SERIALIZER_WORD_CNT_EN
        return 32'(wcnt_m);
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick(input bit r, input bit wr, input logic [31:0] d, input bit txf);
        bit          full_m, e_txwr;
        logic [31:0] w;
        rst = r;
        bus.WRITE_IN = wr;
        bus.DATA_IN  = d;
        bus.TX_FULL  = txf;
        @(negedge clk);
        e_txwr  = !r && hb.size() > 0 && !txf;
        e_valid = !r && hb.size() > 0;
        e_byte  = (hb.size() > 0) ? hb[0] : 8'h00;
        e_vec   = {e_txwr, SW'(mq.size()), mq.size() == DEPTH, mq.size() >= DEPTH - M,
                   (r ? 1'b0 : ready_m), 8'(ovf_m), exp_wc()};
        a_vec   = {bus.TX_WR, bus.FIFO_SIZE, bus.FIFO_FULL, bus.FIFO_NEAR_FULL,
                   bus.READY_OUT, bus.OVERFLOW_CNT, bus.WORD_CNT};
        a_byte  = bus.TX_DATA;
        a_txwr  = bus.TX_WR;
        a_ready = bus.READY_OUT;
        if (r) begin
            mq.delete();
            hb.delete();
            ovf_m   = 0;
            wcnt_m  = 0;
            ready_m = 1'b1;
        end else begin
            full_m  = (mq.size() == DEPTH);
            ready_m = (DEPTH - mq.size()) > M;
            if (e_txwr) begin
                void'(hb.pop_front());
                if (hb.size() == 0) wcnt_m++;
            end
            if (hb.size() == 0 && mq.size() > 0) begin
                w = mq.pop_front();
                hb.push_back(w[31:24]);
                hb.push_back(w[23:16]);
                hb.push_back(w[15:8]);
                hb.push_back(w[7:0]);
            end
            if (wr && !full_m) mq.push_back(d);
            else if (wr && ovf_m < 255) ovf_m++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 32'h0, 0);
        tick(1, 0, 32'h0, 0);
        n_total++;
        if (a_vec !== e_vec) $display("FAIL reset_state: got %h expected %h", a_vec, e_vec);
        else n_pass++;
        n_total++;
        if (a_ready !== 1'b0 || a_txwr !== 1'b0 || a_byte !== 8'h00)
            $display("FAIL reset_outputs: ready=%b tx_wr=%b tx_data=%h expected 0 0 00", a_ready, a_txwr, a_byte);
        else n_pass++;
        tick(0, 0, 32'h0, 0);
        n_total++;
        if (a_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", a_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        int          first_wr = -1;
        int          last_wr  = -1;
        logic [31:0] got = '0;
        int          nb = 0;
        tick(0, 1, 32'h11223344, 0);
        for (int c = 1; c <= 8; c++) begin
            tick(0, 0, 32'h0, 0);
            n_total++;
            if (a_vec !== e_vec) $display("FAIL single_state c%0d: got %h expected %h", c, a_vec, e_vec);
            else n_pass++;
            if (a_txwr === 1'b1) begin
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                got = {got[23:0], a_byte};
                nb++;
            end
        end
        n_total++;
        if (first_wr !== 2) $display("FAIL single_latency: first TX_WR at +%0d expected +2", first_wr);
        else n_pass++;
        n_total++;
        if (nb !== 4 || got !== 32'h11223344 || last_wr - first_wr !== 3)
            $display("FAIL single_bytes: got %0d bytes %h span %0d expected 4 bytes 11223344 span 3", nb, got, last_wr - first_wr);
        else n_pass++;
        n_total++;
        if (bus.FIFO_SIZE !== '0) $display("FAIL single_size: got %0d expected 0", bus.FIFO_SIZE);
        else n_pass++;
    endtask

    task automatic test_burst();
        int          first_wr = -1;
        int          last_wr  = -1;
        int          nb = 0;
        int          bad = 0;
        logic [7:0]  exp_b;
        logic [31:0] wc_exp;
`ifdef ARB_TCP_SERIALIZER_WORD_CNT_EN
        wc_exp = 32'(wcnt_m) + 32'd8;
`else
        wc_exp = 32'd0;
`endif
        for (int c = 0; c < 44; c++) begin
            tick(0, c < 8, 32'(c), 0);
            n_total++;
            if (a_vec !== e_vec) $display("FAIL burst_state c%0d: got %h expected %h", c, a_vec, e_vec);
            else n_pass++;
            if (a_txwr === 1'b1) begin
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                exp_b = (nb % 4 == 3) ? 8'(nb / 4) : 8'h00;
                if (a_byte !== exp_b) bad++;
                nb++;
            end
        end
        n_total++;
        if (nb !== 32 || bad !== 0 || last_wr - first_wr !== 31)
            $display("FAIL burst_stream: got %0d bytes, %0d wrong, span %0d expected 32, 0, 31", nb, bad, last_wr - first_wr);
        else n_pass++;
        n_total++;
        if (bus.WORD_CNT !== wc_exp) $display("FAIL burst_word_cnt: got %0d expected %0d", bus.WORD_CNT, wc_exp);
        else n_pass++;
    endtask

    task automatic test_overflow();
        bit prev_nf = 1'b0;
        tick(1, 0, 32'h0, 0);
        for (int c = 0; c < DEPTH + 3; c++) begin
            tick(0, 1, $urandom, 1);
            n_total++;
            if (a_vec !== e_vec) $display("FAIL ovf_state c%0d: got %h expected %h", c, a_vec, e_vec);
            else n_pass++;
            if (prev_nf) begin
                n_total++;
                if (a_ready !== 1'b0) $display("FAIL ovf_ready c%0d: got %b expected 0", c, a_ready);
                else n_pass++;
            end
            prev_nf = (e_vec[SW+42:SW+43-SW] >= SW'(DEPTH - M));
        end
        tick(0, 0, 32'h0, 1);
        n_total++;
        if (bus.FIFO_FULL !== 1'b1 || bus.OVERFLOW_CNT !== 8'd2 || bus.FIFO_SIZE !== SW'(DEPTH))
            $display("FAIL ovf_final: full=%b ovf=%0d size=%0d expected 1 2 %0d", bus.FIFO_FULL, bus.OVERFLOW_CNT, bus.FIFO_SIZE, DEPTH);
        else n_pass++;
        for (int c = 0; c < 3; c++) tick(0, 0, 32'h0, 0);
        tick(0, 1, 32'hDEAD0000, 0);
        n_total++;
        if (bus.OVERFLOW_CNT !== 8'd3 || bus.FIFO_SIZE !== SW'(DEPTH - 1))
            $display("FAIL push_pop_full: ovf=%0d size=%0d expected 3 %0d", bus.OVERFLOW_CNT, bus.FIFO_SIZE, DEPTH - 1);
        else n_pass++;
        for (int c = 0; c < DEPTH * 4 + 8; c++) begin
            tick(0, 0, 32'h0, 0);
            n_total++;
            if (a_vec !== e_vec || (e_valid && a_byte !== e_byte))
                $display("FAIL drain c%0d: got %h/%h expected %h/%h", c, a_vec, a_byte, e_vec, e_byte);
            else n_pass++;
        end
    endtask

    task automatic test_toggle();
        logic [31:0] got = '0;
        int          nb = 0;
        tick(0, 1, 32'hAABBCCDD, 0);
        for (int c = 1; c <= 20; c++) begin
            tick(0, 0, 32'h0, c % 2 == 1);
            if (e_valid) begin
                n_total++;
                if (a_byte !== e_byte) $display("FAIL toggle_data c%0d: got %h expected %h", c, a_byte, e_byte);
                else n_pass++;
            end
            if (a_txwr === 1'b1) begin
                got = {got[23:0], a_byte};
                nb++;
            end
        end
        n_total++;
        if (nb !== 4 || got !== 32'hAABBCCDD) $display("FAIL toggle_seq: got %0d bytes %h expected 4 bytes aabbccdd", nb, got);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int         nb = 0;
        int         stray = 0;
        logic [7:0] first_b = 8'h00;
        bit         seen = 1'b0;
        tick(0, 1, 32'hCAFEBABE, 0);
        for (int c = 0; c < 12 && nb < 2; c++) begin
            tick(0, 0, 32'h0, 0);
            if (a_txwr === 1'b1) nb++;
        end
        n_total++;
        if (nb !== 2) $display("FAIL mid_timeout: got %0d bytes expected 2", nb);
        else n_pass++;
        tick(1, 0, 32'h0, 0);
        n_total++;
        if (a_txwr !== 1'b0) $display("FAIL mid_reset_txwr: got %b expected 0", a_txwr);
        else n_pass++;
        for (int c = 0; c < 6; c++) begin
            tick(0, 0, 32'h0, 0);
            if (a_txwr !== 1'b0) stray++;
        end
        n_total++;
        if (stray !== 0 || bus.FIFO_SIZE !== '0 || bus.OVERFLOW_CNT !== 8'd0)
            $display("FAIL mid_after: stray=%0d size=%0d ovf=%0d expected 0 0 0", stray, bus.FIFO_SIZE, bus.OVERFLOW_CNT);
        else n_pass++;
        tick(0, 1, 32'h01020304, 0);
        for (int c = 0; c < 8; c++) begin
            tick(0, 0, 32'h0, 0);
            if (a_txwr === 1'b1 && !seen) begin
                first_b = a_byte;
                seen = 1'b1;
            end
        end
        n_total++;
        if (!seen || first_b !== 8'h01) $display("FAIL mid_next_word: seen=%b first=%h expected 1 01", seen, first_b);
        else n_pass++;
    endtask

    task automatic test_random();
        int wp, fp;
        tick(1, 0, 32'h0, 0);
        for (int c = 0; c < 1800; c++) begin
            case (c / 450)
                0:       begin wp = 40; fp = 20; end
                1:       begin wp = 95; fp = 70; end
                2:       begin wp = 70; fp = 40; end
                default: begin wp = 10; fp = 10; end
            endcase
            tick($urandom_range(599, 0) == 0, $urandom_range(99, 0) < wp, $urandom,
                 $urandom_range(99, 0) < fp);
            n_total++;
            if (a_vec !== e_vec || (e_valid && a_byte !== e_byte))
                $display("FAIL random c%0d: got %h/%h expected %h/%h", c, a_vec, a_byte, e_vec, e_byte);
            else n_pass++;
        end
    endtask

    initial begin
        bus.WRITE_IN = 1'b0;
        bus.DATA_IN  = '0;
        bus.TX_FULL  = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_toggle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
